// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Control/datapath bundle for the multicycle MIPS core. The
//            master side is the control unit, the slave side the datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
    parameter int StateWidth = 4
) ();
    // Datapath -> control
    logic [5:0]            Op;
    logic [5:0]            Funct;
    logic                  Zero;
    // Control -> datapath
    logic                  PCWrite;
    logic [1:0]            PCSrc;
    logic                  RegWrite;
    logic                  IorD;
    logic                  MemWrite;
    logic                  IRWrite;
    logic                  RegDst;
    logic                  MemtoReg;
    logic                  ALUSrcA;
    logic                  gpio_i;
    logic [1:0]            ALUSrcB;
    logic [2:0]            ALUControl;
    logic                  InstrDone;
    logic                  Illegal;
    logic [StateWidth-1:0] State;

    modport master (
        input  Op, Funct, Zero,
        output PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite, RegDst,
               MemtoReg, ALUSrcA, gpio_i, ALUSrcB, ALUControl, InstrDone,
               Illegal, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite, RegDst,
               MemtoReg, ALUSrcA, gpio_i, ALUSrcB, ALUControl, InstrDone,
               Illegal, State
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore control FSM for the multicycle MIPS core. Outputs are
//            registered against the next state; only the branch PC write is
//            qualified combinationally by Zero.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int StateWidth = 4
) (
    input  wire logic            clk,
    input  wire logic            reset,   // asynchronous, active low
    multicycle_control_if.master bus
);

    typedef enum logic [StateWidth-1:0] {
        FETCH  = StateWidth'(0),
        DECODE = StateWidth'(1),
        MEMADR = StateWidth'(2),
        MEMRD  = StateWidth'(3),
        MEMWB  = StateWidth'(4),
        MEMWR  = StateWidth'(5),
        EXEC   = StateWidth'(6),
        ALUWB  = StateWidth'(7),
        BRANCH = StateWidth'(8),
        ADDIEX = StateWidth'(9),
        ADDIWB = StateWidth'(10),
        JUMP   = StateWidth'(11),
        GPIOWB = StateWidth'(12)
    } state_t;

    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_funct_ok;
    logic [2:0] w_alu_funct;
    logic       w_illegal;

    // Instruction class latched in DECODE; later states never look at Op.
    logic       r_is_lw;
    logic       r_is_bne;

    // Registered strobes, valid for the state currently held in r_state.
    logic       r_pcwrite;
    logic       r_branch;
    logic [1:0] r_pcsrc;
    logic       r_regwrite;
    logic       r_iord;
    logic       r_memwrite;
    logic       r_irwrite;
    logic       r_regdst;
    logic       r_memtoreg;
    logic       r_alusrca;
    logic       r_gpio_i;
    logic [1:0] r_alusrcb;
    logic [2:0] r_alucontrol;
    logic       r_done;

    // R-type function decode: ALU operation and legality.
    always_comb begin
        w_funct_ok  = 1'b1;
        w_alu_funct = c_alu_add;
        case (bus.Funct)
            6'h20:   w_alu_funct = 3'b010;
            6'h22:   w_alu_funct = 3'b110;
            6'h24:   w_alu_funct = 3'b000;
            6'h25:   w_alu_funct = 3'b001;
            6'h2A:   w_alu_funct = 3'b111;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    // Next-state logic; unsupported opcodes and stray encodings fall to FETCH.
    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH:  w_next_state = DECODE;
            DECODE: begin
                case (bus.Op)
                    6'h23, 6'h2B: w_next_state = MEMADR;
                    6'h00:        w_next_state = w_funct_ok ? EXEC : FETCH;
                    6'h04, 6'h05: w_next_state = BRANCH;
                    6'h08:        w_next_state = ADDIEX;
                    6'h02:        w_next_state = JUMP;
                    6'h3F:        w_next_state = GPIOWB;
                    default:      w_next_state = FETCH;
                endcase
            end
            MEMADR: w_next_state = r_is_lw ? MEMRD : MEMWR;
            MEMRD:  w_next_state = MEMWB;
            EXEC:   w_next_state = ALUWB;
            ADDIEX: w_next_state = ADDIWB;
            default: w_next_state = FETCH;
        endcase
    end

    // The opcode only becomes valid once the IR has loaded, so the illegal
    // flag has to come from the live decode within DECODE itself.
    assign w_illegal = (r_state == DECODE) && (w_next_state == FETCH);

    // State register plus strobes precomputed for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= FETCH;
            r_is_lw      <= 1'b0;
            r_is_bne     <= 1'b0;
            r_pcwrite    <= 1'b1;
            r_branch     <= 1'b0;
            r_pcsrc      <= 2'b00;
            r_regwrite   <= 1'b0;
            r_iord       <= 1'b0;
            r_memwrite   <= 1'b0;
            r_irwrite    <= 1'b1;
            r_regdst     <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_alusrca    <= 1'b0;
            r_gpio_i     <= 1'b0;
            r_alusrcb    <= 2'b01;
            r_alucontrol <= c_alu_add;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == DECODE) begin
                r_is_lw  <= (bus.Op == 6'h23);
                r_is_bne <= (bus.Op == 6'h05);
            end
            r_pcwrite    <= 1'b0;
            r_branch     <= 1'b0;
            r_pcsrc      <= 2'b00;
            r_regwrite   <= 1'b0;
            r_iord       <= 1'b0;
            r_memwrite   <= 1'b0;
            r_irwrite    <= 1'b0;
            r_regdst     <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_alusrca    <= 1'b0;
            r_gpio_i     <= 1'b0;
            r_alusrcb    <= 2'b00;
            r_alucontrol <= c_alu_add;
            r_done       <= 1'b0;
            case (w_next_state)
                FETCH: begin
                    r_irwrite <= 1'b1;
                    r_alusrcb <= 2'b01;
                    r_pcwrite <= 1'b1;
                end
                DECODE: r_alusrcb <= 2'b11;
                MEMADR, ADDIEX: begin
                    r_alusrca <= 1'b1;
                    r_alusrcb <= 2'b10;
                end
                MEMRD: r_iord <= 1'b1;
                MEMWR: begin
                    r_iord     <= 1'b1;
                    r_memwrite <= 1'b1;
                    r_done     <= 1'b1;
                end
                MEMWB: begin
                    r_memtoreg <= 1'b1;
                    r_regwrite <= 1'b1;
                    r_done     <= 1'b1;
                end
                EXEC: begin
                    r_alusrca    <= 1'b1;
                    r_alucontrol <= w_alu_funct;
                end
                ALUWB: begin
                    r_regdst   <= 1'b1;
                    r_regwrite <= 1'b1;
                    r_done     <= 1'b1;
                end
                ADDIWB: begin
                    r_regwrite <= 1'b1;
                    r_done     <= 1'b1;
                end
                BRANCH: begin
                    r_alusrca    <= 1'b1;
                    r_alucontrol <= c_alu_sub;
                    r_pcsrc      <= 2'b01;
                    r_branch     <= 1'b1;
                    r_done       <= 1'b1;
                end
                JUMP: begin
                    r_pcsrc   <= 2'b10;
                    r_pcwrite <= 1'b1;
                    r_done    <= 1'b1;
                end
                GPIOWB: begin
                    r_gpio_i   <= 1'b1;
                    r_regwrite <= 1'b1;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Write strobes are masked by reset so an abort kills them immediately and
    // the FETCH strobes show up as soon as reset is released.
    assign bus.PCWrite    = reset & (r_pcwrite | (r_branch & (bus.Zero ^ r_is_bne)));
    assign bus.RegWrite   = reset & r_regwrite;
    assign bus.MemWrite   = reset & r_memwrite;
    assign bus.IRWrite    = reset & r_irwrite;
    assign bus.InstrDone  = reset & r_done;
    assign bus.Illegal    = reset & w_illegal;
    assign bus.PCSrc      = r_pcsrc;
    assign bus.IorD       = r_iord;
    assign bus.RegDst     = r_regdst;
    assign bus.MemtoReg   = r_memtoreg;
    assign bus.ALUSrcA    = r_alusrca;
    assign bus.gpio_i     = r_gpio_i;
    assign bus.ALUSrcB    = r_alusrcb;
    assign bus.ALUControl = r_alucontrol;
    assign bus.State      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench for multicycle_control. A reference model
//            derives each instruction's state walk and per-cycle strobes.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_control;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.StateWidth(4)) bus ();

    multicycle_control #(.StateWidth(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Packed view: {PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite, RegDst,
    //               MemtoReg, ALUSrcA, gpio_i, ALUSrcB, ALUControl, InstrDone, Illegal}
    function automatic logic [17:0] act_vec();
        return {bus.PCWrite, bus.PCSrc, bus.RegWrite, bus.IorD, bus.MemWrite,
                bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.gpio_i,
                bus.ALUSrcB, bus.ALUControl, bus.InstrDone, bus.Illegal};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h2A: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'h00: return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A);
            6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3F: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction -> list of visited states, starting at FETCH.
    function automatic void build_seq(input logic [5:0] op, input logic [5:0] f,
                                      output int seq[8], output int len);
        for (int i = 0; i < 8; i++) seq[i] = 0;
        seq[0] = 0; seq[1] = 1; len = 2;
        if (is_legal(op, f)) begin
            case (op)
                6'h23: begin seq[2] = 2; seq[3] = 3; seq[4] = 4; len = 5; end
                6'h2B: begin seq[2] = 2; seq[3] = 5; len = 4; end
                6'h00: begin seq[2] = 6; seq[3] = 7; len = 4; end
                6'h08: begin seq[2] = 9; seq[3] = 10; len = 4; end
                6'h04, 6'h05: begin seq[2] = 8; len = 3; end
                6'h02: begin seq[2] = 11; len = 3; end
                default: begin seq[2] = 12; len = 3; end
            endcase
        end
    endfunction

    // Expected strobes for a state of a given instruction.
    function automatic logic [17:0] exp_vec(input int st, input logic [5:0] op,
                                            input logic [5:0] f, input logic z,
                                            input bit last);
        logic pcw = 0, regw = 0, iord = 0, memw = 0, irw = 0, rdst = 0;
        logic m2r = 0, srca = 0, gp = 0, done = 0, ill = 0;
        logic [1:0] pcs = 2'b00, srcb = 2'b00;
        logic [2:0] alu = 3'b010;
        case (st)
            0:  begin irw = 1; srcb = 2'b01; pcw = 1; end
            1:  begin srcb = 2'b11; ill = !is_legal(op, f); end
            2, 9: begin srca = 1; srcb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; regw = 1; end
            5:  begin iord = 1; memw = 1; end
            6:  begin srca = 1; alu = alu_of(f); end
            7:  begin rdst = 1; regw = 1; end
            8:  begin srca = 1; alu = 3'b110; pcs = 2'b01; pcw = (op == 6'h04) ? z : !z; end
            10: regw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            12: begin gp = 1; regw = 1; end
            default: ;
        endcase
        done = last && is_legal(op, f);
        return {pcw, pcs, regw, iord, memw, irw, rdst, m2r, srca, gp, srcb, alu, done, ill};
    endfunction

    // Walks one instruction from FETCH; Op/Funct are scrambled after DECODE.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                             input bit zrand, input logic zfix, input string tag);
        int seq[8];
        int len;
        logic z;
        logic [17:0] e, a;
        build_seq(op, f, seq, len);
        for (int k = 0; k < len; k++) begin
            if (k < 2) begin
                bus.Op = op; bus.Funct = f;
            end else begin
                bus.Op = 6'($urandom); bus.Funct = 6'($urandom);
            end
            z = zrand ? 1'($urandom) : zfix;
            bus.Zero = z;
            #1;
            e = exp_vec(seq[k], op, f, z, k == len - 1);
            a = act_vec();
            n_tests++;
            if (bus.State !== 4'(seq[k]) || a !== e) begin
                n_fail++;
                $display("FAIL %s cyc%0d: state=%0d ctrl=%b, required state=%0d ctrl=%b",
                         tag, k, bus.State, a, seq[k], e);
            end
            if (seq[k] == 8) begin
                bus.Zero = ~z;
                #1;
                n_tests++;
                if (bus.PCWrite !== ((op == 6'h04) ? ~z : z)) begin
                    n_fail++;
                    $display("FAIL %s zero_toggle: PCWrite=%b, required %b",
                             tag, bus.PCWrite, (op == 6'h04) ? ~z : z);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [17:0] a;
        reset = 1'b0;
        bus.Op = 6'h00; bus.Funct = 6'h20; bus.Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = act_vec();
        n_tests++;
        if (bus.State !== 4'd0 || a !== 18'b0_00_0_0_0_0_0_0_0_0_01_010_0_0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d ctrl=%b, required state=0 ctrl=%b",
                     bus.State, a, 18'b0_00_0_0_0_0_0_0_0_0_01_010_0_0);
        end
        reset = 1'b1;
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'h20, 1'b1, 1'b0, "add");
        run_instr(6'h00, 6'h22, 1'b1, 1'b0, "sub");
        run_instr(6'h00, 6'h24, 1'b1, 1'b0, "and");
        run_instr(6'h00, 6'h25, 1'b1, 1'b0, "or");
        run_instr(6'h00, 6'h2A, 1'b1, 1'b0, "slt");
        run_instr(6'h08, 6'h11, 1'b1, 1'b0, "addi");
    endtask

    task automatic test_mem();
        run_instr(6'h23, 6'h00, 1'b1, 1'b0, "lw");
        run_instr(6'h2B, 6'h00, 1'b1, 1'b0, "sw");
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 1'b0, 1'b1, "beq_z1");
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, "beq_z0");
        run_instr(6'h05, 6'h00, 1'b0, 1'b1, "bne_z1");
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, "bne_z0");
    endtask

    task automatic test_jump_gpio();
        run_instr(6'h02, 6'h00, 1'b1, 1'b0, "j");
        run_instr(6'h3F, 6'h00, 1'b1, 1'b0, "in");
    endtask

    task automatic test_illegal();
        run_instr(6'h3E, 6'h20, 1'b1, 1'b0, "ill_op");
        run_instr(6'h00, 6'h03, 1'b1, 1'b0, "ill_funct");
    endtask

    task automatic test_reset_mid();
        bus.Op = 6'h2B; bus.Funct = 6'h00; bus.Zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.State !== 4'd5 || bus.MemWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_memwr: state=%0d MemWrite=%b, required state=5 MemWrite=1",
                     bus.State, bus.MemWrite);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.State !== 4'd0 || bus.MemWrite !== 1'b0 || bus.PCWrite !== 1'b0 ||
            bus.IRWrite !== 1'b0 || bus.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_abort: state=%0d MemWrite=%b PCWrite=%b IRWrite=%b, required 0 0 0 0",
                     bus.State, bus.MemWrite, bus.PCWrite, bus.IRWrite);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.State !== 4'd0 || bus.MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_hold: state=%0d MemWrite=%b, required state=0 MemWrite=0",
                     bus.State, bus.MemWrite);
        end
        reset = 1'b1;
        run_instr(6'h00, 6'h20, 1'b1, 1'b0, "restart_add");
    endtask

    task automatic test_random();
        logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3F, 6'h00};
        logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        logic [5:0] op, f;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 5) == 0) f = 6'($urandom);
            else f = fns[$urandom_range(0, 5)];
            run_instr(op, f, 1'b1, 1'b0, "random");
        end
    endtask

    initial begin
        bus.Op = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0;
        test_reset();
        test_rtype();
        test_mem();
        test_branch();
        test_jump_gpio();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
